// File: rtl/bist_pattern_engine_if.sv
// ---------------------------------------------------------------------------
// bist_pattern_engine_if
//   Bus between the board mode switches / LED stimulus consumer (master) and
//   the BIST pattern engine (slave).
//
//   Signals:
//     mode        master -> slave  requested mode (0 idle, 1 ring, 2 johnson,
//                                  3 lfsr, 4 binary, 5 gray, 6/7 illegal)
//     hold        master -> slave  freezes stepping while high
//     pattern     slave -> master  current pattern (registered)
//     active_mode slave -> master  mode currently executing (registered)
//     step_tick   slave -> master  one-cycle pulse with each new pattern value
//     done        slave -> master  one-cycle pulse on the last step of a run
//     err         slave -> master  sticky illegal-mode flag
//     fsm_state   slave -> master  debug view of the engine FSM state
//
//   Handshake semantics: there is no valid/ready pair on this bus. mode and
//   hold are level signals sampled on every rising clock edge; step_tick and
//   done are single-cycle qualifiers of the registered pattern value and are
//   never held or back-pressured.
// ---------------------------------------------------------------------------
interface bist_pattern_engine_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       mode;
    logic             hold;
    logic [WIDTH-1:0] pattern;
    logic [2:0]       active_mode;
    logic             step_tick;
    logic             done;
    logic             err;
    logic [1:0]       fsm_state;

    modport master (
        output mode,
        output hold,
        input  pattern,
        input  active_mode,
        input  step_tick,
        input  done,
        input  err,
        input  fsm_state
    );

    modport slave (
        input  mode,
        input  hold,
        output pattern,
        output active_mode,
        output step_tick,
        output done,
        output err,
        output fsm_state
    );
endinterface

// File: rtl/bist_pattern_engine.sv
// ---------------------------------------------------------------------------
// bist_pattern_engine
//   BIST / LED pattern engine: mode selection, step-rate prescaler, pattern
//   datapath for ring, johnson, lfsr, binary and gray generators, and
//   run-length completion signalling. A mode change blanks the pattern for
//   one LOAD cycle and then re-seeds the selected generator.
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset
//     bus   slave side of bist_pattern_engine_if (mode/hold in; pattern,
//           active_mode, step_tick, done, err, fsm_state out)
//
//   Parameters: WIDTH (>= 3), DIV clocks per step (>= 1), LFSR_TAPS tap mask,
//   SEED lfsr seed (0 forced to 1), RUN_LEN steps per run (>= 1).
// ---------------------------------------------------------------------------
module bist_pattern_engine #(
    parameter int               WIDTH     = 8,
    parameter int               DIV       = 4,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               RUN_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    bist_pattern_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_RING  = 3'd1;
    localparam logic [2:0] M_JOHN  = 3'd2;
    localparam logic [2:0] M_LFSR  = 3'd3;
    localparam logic [2:0] M_BIN   = 3'd4;
    localparam logic [2:0] M_GRAY  = 3'd5;

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP_W = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RUN_LEN - 1);
    // An all-zero LFSR state would lock up, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0]  LFSR_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    pattern_q, pattern_d;
    logic [2:0]          active_q, active_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WIDTH-1:0]    bin_q, bin_d;

    logic                mode_illegal;
    logic                idle_req;
    logic                load_req;
    logic [WIDTH-1:0]    next_bin;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        active_d  = active_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        div_d     = div_q;
        step_d    = step_q;
        bin_d     = bin_q;
        next_bin  = bin_q + WIDTH'(1);

        // Illegal modes never change the state; they only raise err and the
        // engine carries on as if the previous legal mode were still applied.
        mode_illegal = (bus.mode > M_GRAY);
        idle_req     = (bus.mode == M_IDLE) && (active_q != M_IDLE);
        load_req     = !mode_illegal && (bus.mode != M_IDLE) && (bus.mode != active_q);

        if (mode_illegal) begin
            err_d = 1'b1;
        end

        if (idle_req) begin
            state_d   = ST_IDLE;
            pattern_d = '0;
            active_d  = M_IDLE;
            err_d     = 1'b0;
            div_d     = '0;
            step_d    = '0;
            bin_d     = '0;
        end else if (load_req) begin
            // Blank for one cycle; active_mode already reports the new mode.
            state_d   = ST_LOAD;
            active_d  = bus.mode;
            pattern_d = '0;
            div_d     = '0;
            step_d    = '0;
            bin_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pattern_d = '0;
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    step_d  = '0;
                    bin_d   = '0;
                    pattern_d = (active_q == M_RING) ? WIDTH'(1) :
                                (active_q == M_LFSR) ? LFSR_SEED : '0;
                end
                ST_RUN: begin
                    if (!bus.hold) begin
                        if (div_q == DIV_LAST) begin
                            div_d  = '0;
                            tick_d = 1'b1;
                            case (active_q)
                                M_RING:  pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
                                M_JOHN:  pattern_d = {pattern_q[WIDTH-2:0], ~pattern_q[WIDTH-1]};
                                M_LFSR:  pattern_d = {pattern_q[WIDTH-2:0], ^(pattern_q & LFSR_TAPS)};
                                M_BIN:   pattern_d = pattern_q + WIDTH'(1);
                                M_GRAY: begin
                                    bin_d     = next_bin;
                                    pattern_d = next_bin ^ (next_bin >> 1);
                                end
                                default: pattern_d = pattern_q;
                            endcase
                            // The pattern keeps running across run boundaries.
                            if (step_q == STEP_LAST) begin
                                done_d = 1'b1;
                                step_d = '0;
                            end else begin
                                step_d = step_q + STEP_W'(1);
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            active_q  <= M_IDLE;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            div_q     <= '0;
            step_q    <= '0;
            bin_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            active_q  <= active_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            err_q     <= err_d;
            div_q     <= div_d;
            step_q    <= step_d;
            bin_q     <= bin_d;
        end
    end

    assign bus.pattern     = pattern_q;
    assign bus.active_mode = active_q;
    assign bus.step_tick   = tick_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_bist_pattern_engine
//   Directed bench for bist_pattern_engine (WIDTH 8, DIV 4, RUN_LEN 16,
//   taps B8, seed 01). Expected {done, pattern} values per step are pushed
//   to exp_q and popped when the engine raises step_tick.
// ---------------------------------------------------------------------------
module tb_bist_pattern_engine;

    localparam int W       = 8;
    localparam int DIV     = 4;
    localparam int RUN_LEN = 16;
    localparam int BUDGET  = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_pattern_engine_if #(.WIDTH(W)) bus ();

    bist_pattern_engine #(
        .WIDTH    (W),
        .DIV      (DIV),
        .LFSR_TAPS(8'hB8),
        .SEED     (8'h01),
        .RUN_LEN  (RUN_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];   // {done, pattern}
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) step();
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (bus.step_tick !== 1'b1 && cyc < BUDGET);
        chk("tick_timeout", {31'd0, bus.step_tick}, 32'd1);
    endtask

    task automatic drain(input string tag, input int n);
        int c;
        logic [W:0] e;
        for (int i = 0; i < n; i++) begin
            wait_tick(c);
            chk({tag, "_spacing"}, c, DIV);
            e = exp_q.pop_front();
            chk(tag, {bus.done, bus.pattern}, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        int adv;
        int zeros;
        int dones;
        int bad;
        int t;
        logic [W-1:0] lfsr_ref [8];
        lfsr_ref = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

        // reset with mode 3 applied
        bus.mode = 3'd3;
        bus.hold = 1'b0;
        rst      = 1'b1;
        tick(2);
        chk("rst_pattern", bus.pattern, 0);
        chk("rst_active", bus.active_mode, 0);
        chk("rst_tick", bus.step_tick, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_state", bus.fsm_state, S_IDLE);

        // LFSR: LOAD then seed, then known first steps
        rst = 1'b0;
        step();
        chk("lfsr_load_pat", bus.pattern, 0);
        chk("lfsr_load_mode", bus.active_mode, 3);
        chk("lfsr_load_state", bus.fsm_state, S_LOAD);
        step();
        chk("lfsr_seed", bus.pattern, 8'h01);
        chk("lfsr_run_state", bus.fsm_state, S_RUN);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, lfsr_ref[i]});
        drain("lfsr", 8);

        // LFSR period: back to 01 after 255 steps, never 00, 15 runs done
        adv = 8; zeros = 0; dones = 0;
        do begin
            wait_tick(c);
            adv++;
            if (bus.pattern == '0) zeros++;
            if (bus.done) dones++;
        end while (bus.pattern !== 8'h01 && adv < 300);
        chk("lfsr_period", adv, 255);
        chk("lfsr_nonzero", zeros, 0);
        chk("lfsr_done_cnt", dones, 15);

        // gray: blank, seed 00, then 01 03 02 06 07 05 04
        bus.mode = 3'd5;
        step();
        chk("gray_blank", bus.pattern, 0);
        chk("gray_active", bus.active_mode, 5);
        chk("gray_blank_tick", bus.step_tick, 0);
        step();
        chk("gray_seed", bus.pattern, 0);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h07});
        exp_q.push_back({1'b0, 8'h05});
        exp_q.push_back({1'b0, 8'h04});
        drain("gray", 7);

        // ring: 01 02 .. 80 01 ..; done on 16th step
        bus.mode = 3'd1;
        step();
        chk("ring_blank", bus.pattern, 0);
        chk("ring_active", bus.active_mode, 1);
        step();
        chk("ring_seed", bus.pattern, 8'h01);
        for (int k = 1; k <= 16; k++) begin
            t = 1 << (k % 8);
            exp_q.push_back({(k == 16), t[W-1:0]});
        end
        drain("ring", 16);
        step();
        chk("ring_tick_pulse", bus.step_tick, 0);
        chk("ring_done_pulse", bus.done, 0);

        // johnson: 01 03 .. FF FE .. 80 00 (done), then 01 again
        bus.mode = 3'd2;
        step();
        chk("john_blank", bus.pattern, 0);
        chk("john_active", bus.active_mode, 2);
        step();
        chk("john_seed", bus.pattern, 0);
        for (int k = 1; k <= 17; k++) begin
            int m;
            m = k % 16;
            t = (m <= 8) ? ((1 << m) - 1) : (255 << (m - 8));
            exp_q.push_back({(k == 16), t[W-1:0]});
        end
        drain("john", 17);

        // hold mid-period: frozen 10 cycles, resumes at remaining distance
        tick(2);
        bus.hold = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (bus.pattern !== 8'h01 || bus.step_tick !== 1'b0) bad++;
        end
        chk("hold_frozen", bad, 0);
        bus.hold = 1'b0;
        wait_tick(c);
        chk("hold_resume_dist", c, 2);
        chk("hold_resume_pat", bus.pattern, 8'h03);

        // hold on the edge where the advance would happen
        tick(3);
        bus.hold = 1'b1;
        step();
        chk("hold_last_tick", bus.step_tick, 0);
        chk("hold_last_pat", bus.pattern, 8'h03);
        bus.hold = 1'b0;
        step();
        chk("release_tick", bus.step_tick, 1);
        chk("release_pat", bus.pattern, 8'h07);

        // mode change during hold still goes through LOAD
        bus.hold = 1'b1;
        bus.mode = 3'd4;
        step();
        chk("hold_load_mode", bus.active_mode, 4);
        chk("hold_load_state", bus.fsm_state, S_LOAD);
        chk("hold_load_pat", bus.pattern, 0);
        step();
        chk("hold_run_state", bus.fsm_state, S_RUN);
        bad = 0;
        repeat (6) begin
            step();
            if (bus.pattern !== 8'h00 || bus.step_tick !== 1'b0) bad++;
        end
        chk("hold_bin_frozen", bad, 0);
        bus.hold = 1'b0;

        // binary: counts 1..FF then wraps to 00
        for (int k = 1; k <= 256; k++) begin
            wait_tick(c);
            chk("bin_spacing", c, DIV);
            chk("bin", bus.pattern, k[W-1:0]);
        end

        // illegal mode during ring: keeps rotating, err sticky
        bus.mode = 3'd1;
        step();
        step();
        chk("ill_seed", bus.pattern, 8'h01);
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h04});
        drain("ill_ring", 2);
        bus.mode = 3'd6;
        step();
        chk("ill_err", bus.err, 1);
        chk("ill_active", bus.active_mode, 1);
        wait_tick(c);
        chk("ill_rotate", bus.pattern, 8'h08);
        chk("ill_err_sticky", bus.err, 1);

        // idle: immediate, clears err, no ticks
        bus.mode = 3'd0;
        step();
        chk("idle_pat", bus.pattern, 0);
        chk("idle_active", bus.active_mode, 0);
        chk("idle_err", bus.err, 0);
        chk("idle_state", bus.fsm_state, S_IDLE);
        bad = 0;
        repeat (8) begin
            step();
            if (bus.pattern !== 8'h00 || bus.step_tick !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // mode change during LOAD restarts LOAD
        bus.mode = 3'd3;
        step();
        chk("reload_a_mode", bus.active_mode, 3);
        bus.mode = 3'd1;
        step();
        chk("reload_b_mode", bus.active_mode, 1);
        chk("reload_b_state", bus.fsm_state, S_LOAD);
        chk("reload_b_pat", bus.pattern, 0);
        step();
        chk("reload_seed", bus.pattern, 8'h01);
        wait_tick(c);
        chk("reload_dist", c, DIV);
        chk("reload_step", bus.pattern, 8'h02);

        // reset mid-run
        rst = 1'b1;
        step();
        chk("midrst_pat", bus.pattern, 0);
        chk("midrst_active", bus.active_mode, 0);
        chk("midrst_state", bus.fsm_state, S_IDLE);
        bus.mode = 3'd0;
        rst = 1'b0;
        step();
        chk("post_rst_pat", bus.pattern, 0);
        chk("post_rst_active", bus.active_mode, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_pattern_engine.md
# bist_pattern_engine

Parametrised BIST/LED pattern engine that replaces the fixed four-state BIST control path plus its separate enable-driven generators. It combines mode selection, a step-rate prescaler, the pattern datapath for five generator types, and run-length completion signalling. It sits between the board mode switches and the LED/DUT stimulus bus. Mode changes are blanked for one cycle and re-seeded deterministically.

## Interface
- `WIDTH`, 8: pattern width; must be ≥ 3.
- `DIV`, 4: clocks per pattern step; must be ≥ 1.
- `LFSR_TAPS`, 8'hB8: WIDTH-bit tap mask for the Fibonacci LFSR.
- `SEED`, 1: LFSR seed, WIDTH bits; a value of 0 is forced to 1.
- `RUN_LEN`, 16: steps per run; must be ≥ 1.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  3  0 idle, 1 ring, 2 johnson, 3 lfsr, 4 binary count, 5 gray count; 6 and 7 are illegal.
- `hold`  in  1  freezes stepping while high.
- `pattern`  out  WIDTH  current pattern (registered).
- `active_mode`  out  3  mode currently executing (registered).
- `step_tick`  out  1  one-cycle pulse aligned with each new pattern value.
- `done`  out  1  one-cycle pulse on the step completing each RUN_LEN-step run.
- `err`  out  1  sticky flag: an illegal mode was sampled.

## Operation
- FSM states are IDLE, LOAD and RUN. Internal counters:
  - `div_cnt`: counts 0..DIV-1.
  - `step_cnt`: counts 0..RUN_LEN-1.
  - `bin`: WIDTH-bit counter for the gray mode.
- Reset: state IDLE, pattern 0, active_mode 0, step_tick 0, done 0, err 0, all counters 0. Reset overrides everything, including mid-run.
- `mode` is sampled every edge. Priority:
  - mode 6 or 7: ignore it and keep the current state; err <= 1.
  - mode 0 and active_mode ≠ 0: go to IDLE; pattern <= 0; active_mode <= 0; err <= 0; counters cleared.
  - mode in 1..5 and mode ≠ active_mode (from any state, including LOAD): go to LOAD; active_mode <= mode; pattern <= 0 (blank); counters cleared.
- LOAD always lasts exactly one cycle, then goes to RUN. It loads the seed, clears div_cnt, step_cnt and bin, and ignores hold. Seeds:
  - ring: 1
  - johnson: 0
  - lfsr: SEED (0 forced to 1)
  - binary: 0
  - gray: 0
- RUN with hold = 1: pattern, div_cnt and step_cnt are frozen. Mode changes are still honoured.
- RUN with hold = 0: div_cnt increments. When div_cnt = DIV-1, that edge advances the pattern, sets div_cnt <= 0 and step_tick <= 1. Step rules:
  - ring: rotate left, {p[W-2:0], p[W-1]}.
  - johnson: {p[W-2:0], ~p[W-1]}.
  - lfsr: {p[W-2:0], ^(p & LFSR_TAPS)}.
  - binary: p + 1 modulo 2^WIDTH; wraps from all-ones to 0.
  - gray: bin <= bin + 1; pattern <= next_bin ^ (next_bin >> 1).
- Run-length counting, on each advance:
  - If step_cnt = RUN_LEN-1: done <= 1 and step_cnt <= 0. The pattern keeps running.
  - Otherwise step_cnt increments.
- step_tick and done are low on every edge that does not advance.
- In IDLE, pattern stays 0 and no ticks are produced.
- err clears only on reset or on entering IDLE.

## Timing
- Mode change sampled at edge E0:
  - After E0: LOAD, pattern 0, active_mode already equals the new mode.
  - After E0+1: RUN with the seed on pattern.
  - First advance at edge E0+1+DIV.
  - Changing mode again during LOAD restarts LOAD at E0+1.
- Steady state: one advance every DIV cycles. With DIV = 1, the pattern steps every cycle.
- step_tick and done rise on the same edge as the new pattern value. done coincides with step_tick.
- hold asserted on the edge where div_cnt = DIV-1 suppresses that advance. Counting resumes from the frozen div_cnt.
- Mode 0 is effective one edge after it is sampled. There is no LOAD blank on the way into IDLE; pattern is 0 immediately.

## Test plan
- Reset: assert rst for 2 cycles while mode = 3 → pattern 00, active_mode 0, step_tick 0, done 0, err 0. Deassert rst → LOAD (pattern 00, active_mode 3), then pattern 01.
- Ring (WIDTH 8, DIV 4): mode = 1 → pattern 00 for 1 cycle, then 01, then 02 four cycles later. Sequence continues …, 80, 01; step_tick is high exactly 1 cycle in every 4.
- Johnson (RUN_LEN 16): mode = 2 → sequence 00, 01, 03, …, FF, FE, …, 80, 00. done pulses together with the 16th step_tick, which is when pattern returns to 00; then it repeats.
- LFSR and gray: mode = 3 → 01, 02, 04, 08, 11, …, period 255, never 00. Then mode = 5 → one 00 blank cycle, then 00, 01, 03, 02, 06, 07.
- Hold: hold = 1 for 10 cycles mid-run → pattern and step_tick frozen. Release → next advance at the remaining div_cnt distance. Mode change during hold still goes through LOAD.
- Illegal mode and idle: mode = 6 during ring → pattern keeps rotating and err = 1. Then mode = 0 → next cycle pattern 00, active_mode 0, err 0.
